// File: rtl/mont_exp_sequencer_pkg.sv
// Shared FSM types and constants for the modular-exponentiation sequencer.
// Optional build macro used by the top: MONT_EXP_SKIP_LZ_EN.
package mont_exp_sequencer_pkg;

  localparam int MONT_ONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TO_BASE,
    ST_TO_ONE,
    ST_SQR,
    ST_MUL,
    ST_FROM,
    ST_DONE
  } ModExpState;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } ModExpPhase;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mont_exp_sequencer_bitscan.sv
// Leading-one detector: index of the most significant set bit, plus an all-zero flag.
module mont_exp_bitscan #(
  parameter int W  = 256,
  parameter int IW = 8
) (
  input  logic [W-1:0]  value,
  output logic [IW-1:0] msb_idx,
  output logic          is_zero
);

  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < W; i++) begin
      if (value[i]) msb_idx = IW'(i);
    end
    is_zero = (value == '0);
  end

endmodule

// File: rtl/mont_exp_sequencer.sv
// MSB-first square-and-multiply sequencer driving an external Montgomery multiplier.
// Build option MONT_EXP_SKIP_LZ_EN: skip leading zero exponent bits (same results, fewer ops).
//
// state      | meaning
// IDLE       | i_ready high, waiting for a command
// TO_BASE    | bm  = mont(base, r2), base into Montgomery domain
// TO_ONE     | acc = mont(1, r2) = R mod n
// SQR        | acc = mont(acc, acc) for exponent bit idx
// MUL        | acc = mont(acc, bm), only when exponent bit idx is set
// FROM       | result = mont(acc, 1), back to normal domain
// DONE       | o_valid high, holding o_out until o_ready
// Each op state runs an ISSUE phase (request handshake) then a WAIT phase (response capture).
module mont_exp_sequencer
  import mont_exp_sequencer_pkg::*;
#(
  parameter int MOD_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [MOD_WIDTH-1:0] i_base,
  input  logic [MOD_WIDTH-1:0] i_exponent,
  input  logic [MOD_WIDTH-1:0] i_modulus,
  input  logic [MOD_WIDTH-1:0] i_r2,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [MOD_WIDTH-1:0] o_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [MOD_WIDTH-1:0] m_a,
  output logic [MOD_WIDTH-1:0] m_b,
  output logic [MOD_WIDTH-1:0] m_modulus,
  input  logic                 m_resp_valid,
  output logic                 m_resp_ready,
  input  logic [MOD_WIDTH-1:0] m_resp
);

  localparam int IW = idx_width(MOD_WIDTH);
  localparam logic [MOD_WIDTH-1:0] ONE = MOD_WIDTH'(MONT_ONE);

  typedef struct packed {
    logic [MOD_WIDTH-1:0] base;
    logic [MOD_WIDTH-1:0] exponent;
    logic [MOD_WIDTH-1:0] modulus;
    logic [MOD_WIDTH-1:0] r2;
  } ModExpIn;

  typedef struct packed {
    logic [MOD_WIDTH-1:0] a;
    logic [MOD_WIDTH-1:0] b;
    logic [MOD_WIDTH-1:0] modulus;
  } MontgomeryIn;

  typedef struct packed {
    logic [MOD_WIDTH-1:0] result;
  } MontgomeryOut;

  ModExpIn              cmd_in;
  MontgomeryIn          req;
  MontgomeryOut         rsp;
  ModExpState           state;
  ModExpPhase           phase;
  logic [MOD_WIDTH-1:0] exp_q;
  logic [MOD_WIDTH-1:0] r2_q;
  logic [MOD_WIDTH-1:0] bm;
  logic [IW-1:0]        idx;
  logic                 exp_zero_q;
  logic [IW-1:0]        start_idx;
  logic                 start_zero;
  logic                 bit_set;
  logic                 last_bit;

  assign cmd_in = '{base: i_base, exponent: i_exponent, modulus: i_modulus, r2: i_r2};
  assign rsp    = '{result: m_resp};

  assign m_a       = req.a;
  assign m_b       = req.b;
  assign m_modulus = req.modulus;

  // Responses are always accepted; outside WAIT they are simply discarded,
  // which drains anything left in flight from before a reset.
  assign m_resp_ready = 1'b1;

  assign bit_set  = exp_q[idx];
  assign last_bit = (idx == '0);

`ifdef MONT_EXP_SKIP_LZ_EN
  mont_exp_bitscan #(
    .W  (MOD_WIDTH),
    .IW (IW)
  ) u_bitscan (
    .value   (cmd_in.exponent),
    .msb_idx (start_idx),
    .is_zero (start_zero)
  );
`else
  assign start_idx  = IW'(MOD_WIDTH - 1);
  assign start_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= PH_ISSUE;
      i_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_out      <= '0;
      m_valid    <= 1'b0;
      req        <= '0;
      exp_q      <= '0;
      r2_q       <= '0;
      bm         <= '0;
      idx        <= '0;
      exp_zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid && i_ready) begin
            i_ready    <= 1'b0;
            exp_q      <= cmd_in.exponent;
            r2_q       <= cmd_in.r2;
            idx        <= start_idx;
            exp_zero_q <= start_zero;
            req        <= '{a: cmd_in.base, b: cmd_in.r2, modulus: cmd_in.modulus};
            m_valid    <= 1'b1;
            phase      <= PH_ISSUE;
            state      <= ST_TO_BASE;
          end
        end
        ST_DONE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          if (phase == PH_ISSUE) begin
            if (m_ready) begin
              m_valid <= 1'b0;
              phase   <= PH_WAIT;
            end
          end else if (m_resp_valid) begin
            // The captured result feeds the next request directly, so the
            // request operand register doubles as the accumulator.
            phase   <= PH_ISSUE;
            m_valid <= 1'b1;
            case (state)
              ST_TO_BASE: begin
                bm    <= rsp.result;
                req.a <= ONE;
                req.b <= r2_q;
                state <= ST_TO_ONE;
              end
              ST_TO_ONE: begin
                req.a <= rsp.result;
                if (exp_zero_q) begin
                  req.b <= ONE;
                  state <= ST_FROM;
                end else begin
                  req.b <= rsp.result;
                  state <= ST_SQR;
                end
              end
              ST_SQR: begin
                req.a <= rsp.result;
                if (bit_set) begin
                  req.b <= bm;
                  state <= ST_MUL;
                end else if (last_bit) begin
                  req.b <= ONE;
                  state <= ST_FROM;
                end else begin
                  req.b <= rsp.result;
                  idx   <= idx - IW'(1);
                  state <= ST_SQR;
                end
              end
              ST_MUL: begin
                req.a <= rsp.result;
                if (last_bit) begin
                  req.b <= ONE;
                  state <= ST_FROM;
                end else begin
                  req.b <= rsp.result;
                  idx   <= idx - IW'(1);
                  state <= ST_SQR;
                end
              end
              ST_FROM: begin
                m_valid <= 1'b0;
                o_out   <= rsp.result;
                o_valid <= 1'b1;
                state   <= ST_DONE;
              end
              default: begin
                m_valid <= 1'b0;
                i_ready <= 1'b1;
                state   <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_sequencer.sv
// Self-checking bench: 8-bit operands, n=13, r2=3, behavioural Montgomery multiplier responder.
`timescale 1ns/1ps
module tb_mont_exp_sequencer;

  localparam int W = 8;
  localparam int N_INT = 13;
  localparam logic [W-1:0] N  = 8'd13;
  localparam logic [W-1:0] R2 = 8'd3;
`ifdef MONT_EXP_SKIP_LZ_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [W-1:0] i_base = '0, i_exponent = '0, i_modulus = '0, i_r2 = '0;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [W-1:0] o_out;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_a, m_b, m_modulus;
  logic         m_resp_valid;
  logic         m_resp_ready;
  logic [W-1:0] m_resp;

  always #5 clk = ~clk;

  mont_exp_sequencer #(.MOD_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .i_base       (i_base),
    .i_exponent   (i_exponent),
    .i_modulus    (i_modulus),
    .i_r2         (i_r2),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_out        (o_out),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_a          (m_a),
    .m_b          (m_b),
    .m_modulus    (m_modulus),
    .m_resp_valid (m_resp_valid),
    .m_resp_ready (m_resp_ready),
    .m_resp       (m_resp)
  );

  int passed = 0;
  int total  = 0;
  int r_inv  = 0;
  int ready_delay = 0;
  int resp_delay  = 0;
  bit rand_delays = 1'b0;
  int stale_req   = 0;
  int overlap_err = 0;
  int proto_err   = 0;
  logic [2*W-1:0] ops[$];
  logic [2*W-1:0] exp_ops[$];

  function automatic int mont(input int a, input int b);
    return (a * b * r_inv) % N_INT;
  endfunction

  function automatic int modexp_ref(input int b, input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = (r * b) % N_INT;
    return r % N_INT;
  endfunction

  function automatic int exp_op_count(input int e);
    int bits = W;
    if (SKIP) bits = (e == 0) ? 0 : $clog2(e + 1);
    return 3 + bits + $countones(e);
  endfunction

  // Square-and-multiply in the Montgomery domain, listing every product request in order.
  task automatic build_expected(input int b, input int e);
    int acc, bm, top;
    exp_ops.delete();
    exp_ops.push_back({8'(b), R2});
    bm = mont(b, int'(R2));
    exp_ops.push_back({8'd1, R2});
    acc = mont(1, int'(R2));
    top = W - 1;
    if (SKIP) begin
      top = -1;
      for (int i = 0; i < W; i++) if (e[i]) top = i;
    end
    for (int i = top; i >= 0; i--) begin
      exp_ops.push_back({8'(acc), 8'(acc)});
      acc = mont(acc, acc);
      if (e[i]) begin
        exp_ops.push_back({8'(acc), 8'(bm)});
        acc = mont(acc, bm);
      end
    end
    exp_ops.push_back({8'(acc), 8'd1});
  endtask

  initial begin : responder
    int hold_cnt, resp_cnt, stale_done;
    bit outstanding, req_seen;
    logic [W-1:0] ra, rb, rm, pend;
    hold_cnt = 0; resp_cnt = 0; stale_done = 0;
    outstanding = 1'b0; req_seen = 1'b0;
    ra = '0; rb = '0; rm = '0; pend = '0;
    m_ready = 1'b0; m_resp_valid = 1'b0; m_resp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_ready = 1'b0; m_resp_valid = 1'b0;
        outstanding = 1'b0; req_seen = 1'b0;
      end else begin
        if (m_resp_valid) begin
          m_resp_valid = 1'b0;
          outstanding = 1'b0;
        end
        if (m_ready) begin
          m_ready = 1'b0;
          outstanding = 1'b1;
          pend = 8'(mont(int'(ra), int'(rb)));
          resp_cnt = rand_delays ? int'($urandom_range(0, 3)) : resp_delay;
        end
        if (m_valid) begin
          if (outstanding) overlap_err++;
          if (!req_seen) begin
            req_seen = 1'b1;
            ra = m_a; rb = m_b; rm = m_modulus;
            hold_cnt = rand_delays ? int'($urandom_range(0, 3)) : ready_delay;
          end else if ({m_a, m_b, m_modulus} !== {ra, rb, rm}) begin
            proto_err++;
          end
          if (hold_cnt == 0) begin
            if (rm !== N) proto_err++;
            m_ready = 1'b1;
            req_seen = 1'b0;
            ops.push_back({ra, rb});
          end else begin
            hold_cnt--;
          end
        end
        if (stale_done != stale_req) begin
          stale_done = stale_req;
          m_resp = 8'hAA;
          m_resp_valid = 1'b1;
        end else if (outstanding && resp_cnt == 0 && m_resp_ready) begin
          m_resp = pend;
          m_resp_valid = 1'b1;
        end else if (outstanding && resp_cnt > 0) begin
          resp_cnt--;
        end
      end
    end
  end

  task automatic do_cmd(input logic [W-1:0] b, input logic [W-1:0] e, input bit handshake,
                        output logic [W-1:0] res, output int nops, output int seq_bad);
    int cyc, base_i;
    build_expected(int'(b), int'(e));
    base_i = ops.size();
    @(negedge clk);
    cyc = 0;
    while (!i_ready && cyc < 200) begin @(negedge clk); cyc++; end
    i_valid = 1'b1; i_base = b; i_exponent = e; i_modulus = N; i_r2 = R2;
    @(negedge clk);
    i_valid = 1'b0;
    i_base = 8'($urandom); i_exponent = 8'($urandom);
    i_modulus = 8'($urandom); i_r2 = 8'($urandom);
    cyc = 0;
    while (!o_valid && cyc < 3000) begin @(negedge clk); cyc++; end
    total++;
    if (o_valid !== 1'b1) $display("FAIL cmd_timeout: o_valid=%b expected 1 (b=%0d e=%0d)", o_valid, b, e);
    else passed++;
    res = o_out;
    nops = ops.size() - base_i;
    seq_bad = (nops != exp_ops.size()) ? 1 : 0;
    if (seq_bad == 0)
      foreach (exp_ops[k]) if (ops[base_i + k] !== exp_ops[k]) seq_bad++;
    if (handshake) begin
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (i_ready !== 1'b1) $display("FAIL rst_i_ready: got %b expected 1", i_ready); else passed++;
    total++; if (o_valid !== 1'b0) $display("FAIL rst_o_valid: got %b expected 0", o_valid); else passed++;
    total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid: got %b expected 0", m_valid); else passed++;
    total++; if (m_resp_ready !== 1'b1) $display("FAIL rst_m_resp_ready: got %b expected 1", m_resp_ready); else passed++;
    total++; if ({o_out, m_a, m_b, m_modulus} !== 32'h0) $display("FAIL rst_operands: got %h expected 0", {o_out, m_a, m_b, m_modulus}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] res; int nops, sb;
    do_cmd(8'd2, 8'd5, 1'b1, res, nops, sb);
    total++; if (res !== 8'd6) $display("FAIL basic_result: got %0d expected 6", res); else passed++;
    total++; if (nops != (SKIP ? 8 : 13)) $display("FAIL basic_ops: got %0d expected %0d", nops, SKIP ? 8 : 13); else passed++;
    total++; if (sb != 0) $display("FAIL basic_seq: got %0d bad ops expected 0", sb); else passed++;
  endtask

  task automatic test_all_ones();
    logic [W-1:0] res; int nops, sb;
    do_cmd(8'd2, 8'hFF, 1'b1, res, nops, sb);
    total++; if (res !== 8'd8) $display("FAIL ones_result: got %0d expected 8", res); else passed++;
    total++; if (nops != 19) $display("FAIL ones_ops: got %0d expected 19", nops); else passed++;
    total++; if (sb != 0) $display("FAIL ones_seq: got %0d bad ops expected 0", sb); else passed++;
  endtask

  task automatic test_boundaries();
    logic [W-1:0] res; int nops, sb;
    do_cmd(8'd7, 8'd0, 1'b1, res, nops, sb);
    total++; if (res !== 8'd1) $display("FAIL exp0_result: got %0d expected 1", res); else passed++;
    total++; if (nops != exp_op_count(0)) $display("FAIL exp0_ops: got %0d expected %0d", nops, exp_op_count(0)); else passed++;
    total++; if (sb != 0) $display("FAIL exp0_seq: got %0d bad ops expected 0", sb); else passed++;
    do_cmd(8'd0, 8'd3, 1'b1, res, nops, sb);
    total++; if (res !== 8'd0) $display("FAIL base0_result: got %0d expected 0", res); else passed++;
    total++; if (nops != exp_op_count(3)) $display("FAIL base0_ops: got %0d expected %0d", nops, exp_op_count(3)); else passed++;
  endtask

  task automatic test_mult_stall();
    logic [W-1:0] res; int nops, sb;
    ready_delay = 5; resp_delay = 7;
    do_cmd(8'd2, 8'd5, 1'b1, res, nops, sb);
    ready_delay = 0; resp_delay = 0;
    total++; if (res !== 8'd6) $display("FAIL stall_result: got %0d expected 6", res); else passed++;
    total++; if (sb != 0) $display("FAIL stall_seq: got %0d bad ops expected 0", sb); else passed++;
    total++; if (proto_err != 0) $display("FAIL stall_stable: got %0d unstable requests expected 0", proto_err); else passed++;
    total++; if (overlap_err != 0) $display("FAIL stall_outstanding: got %0d overlaps expected 0", overlap_err); else passed++;
  endtask

  task automatic test_out_backpressure();
    logic [W-1:0] res; int nops, sb;
    do_cmd(8'd2, 8'd5, 1'b0, res, nops, sb);
    total++; if (res !== 8'd6) $display("FAIL bp_result: got %0d expected 6", res); else passed++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++; if (o_valid !== 1'b1 || o_out !== 8'd6) $display("FAIL bp_hold: o_valid=%b o_out=%0d expected 1/6", o_valid, o_out); else passed++;
      total++; if (i_ready !== 1'b0) $display("FAIL bp_i_ready: got %b expected 0", i_ready); else passed++;
    end
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    total++; if (i_ready !== 1'b1) $display("FAIL bp_release_i_ready: got %b expected 1", i_ready); else passed++;
    total++; if (o_valid !== 1'b0) $display("FAIL bp_release_o_valid: got %b expected 0", o_valid); else passed++;
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] res; int nops, sb, cyc, target;
    // 0x1F: bits 7..5 clear, so SQR at idx 4 is the 6th op (3rd when leading zeros are skipped).
    target = ops.size() + (SKIP ? 3 : 6);
    resp_delay = 4;
    @(negedge clk);
    i_valid = 1'b1; i_base = 8'd2; i_exponent = 8'h1F; i_modulus = N; i_r2 = R2;
    @(negedge clk);
    i_valid = 1'b0;
    cyc = 0;
    while (ops.size() < target && cyc < 500) begin @(negedge clk); cyc++; end
    total++; if (ops.size() < target) $display("FAIL rst6_reach_sqr: got %0d ops expected %0d", ops.size(), target); else passed++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    resp_delay = 0;
    @(negedge clk);
    total++; if (i_ready !== 1'b1) $display("FAIL rst6_i_ready: got %b expected 1", i_ready); else passed++;
    total++; if (m_valid !== 1'b0) $display("FAIL rst6_m_valid: got %b expected 0", m_valid); else passed++;
    total++; if (o_valid !== 1'b0) $display("FAIL rst6_o_valid: got %b expected 0", o_valid); else passed++;
    total++; if ({m_a, m_b} !== 16'h0) $display("FAIL rst6_operands: got %h expected 0", {m_a, m_b}); else passed++;
    stale_req++;
    repeat (3) @(negedge clk);
    total++; if (i_ready !== 1'b1 || m_valid !== 1'b0 || o_valid !== 1'b0)
      $display("FAIL rst6_stale_drop: i_ready=%b m_valid=%b o_valid=%b expected 1/0/0", i_ready, m_valid, o_valid);
    else passed++;
    do_cmd(8'd3, 8'd3, 1'b1, res, nops, sb);
    total++; if (res !== 8'd1) $display("FAIL rst6_result: got %0d expected 1", res); else passed++;
    total++; if (sb != 0) $display("FAIL rst6_seq: got %0d bad ops expected 0", sb); else passed++;
  endtask

  task automatic test_random();
    logic [W-1:0] res, b, e; int nops, sb;
    rand_delays = 1'b1;
    for (int it = 0; it < 10; it++) begin
      b = 8'($urandom_range(0, N_INT - 1));
      e = 8'($urandom);
      do_cmd(b, e, 1'b1, res, nops, sb);
      total++; if (int'(res) != modexp_ref(int'(b), int'(e)))
        $display("FAIL rand_result: b=%0d e=%0d got %0d expected %0d", b, e, res, modexp_ref(int'(b), int'(e)));
      else passed++;
      total++; if (nops != exp_op_count(int'(e))) $display("FAIL rand_ops: e=%0d got %0d expected %0d", e, nops, exp_op_count(int'(e))); else passed++;
      total++; if (sb != 0) $display("FAIL rand_seq: e=%0d got %0d bad ops expected 0", e, sb); else passed++;
    end
    rand_delays = 1'b0;
    total++; if (overlap_err != 0 || proto_err != 0)
      $display("FAIL rand_protocol: overlaps=%0d unstable=%0d expected 0/0", overlap_err, proto_err);
    else passed++;
  endtask

  initial begin
    for (int k = 1; k < N_INT; k++) if (((1 << W) * k) % N_INT == 1) r_inv = k;
    test_reset();
    test_basic();
    test_all_ones();
    test_boundaries();
    test_mult_stall();
    test_out_backpressure();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
